// File: rtl/mem_access_ctrl.sv
// Load/store sequencer over a word-only memory: sub-word loads by lane extraction, sub-word stores by read-modify-write.
// Optional misalignment trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [DEPTH-1:0] req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [DEPTH-1:0] mem_rd_addr_o,
    input  logic [31:0]      mem_rd_data_i,
    output logic             mem_write_o,
    output logic [DEPTH-1:0] mem_wr_addr_o,
    output logic [31:0]      mem_wr_data_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           state;
    logic [DEPTH-1:0] addr_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             misaligned;

    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        case (req_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr_i[0];
            default: misaligned = |req_addr_i[1:0];
        endcase
`endif
    end

    // Size 3 behaves as word everywhere: only size[1] distinguishes word from sub-word.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lsb,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] shifted;
        shifted = word >> {lsb, 3'b000};
        if (size[1]) begin
            extract = word;
        end else if (size[0]) begin
            shifted = lsb[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            extract = {{16{shifted[15] & ~uns}}, shifted[15:0]};
        end else begin
            extract = {{24{shifted[7] & ~uns}}, shifted[7:0]};
        end
    endfunction

    always_comb begin
        mem_wr_data_o = rdata_q;
        if (size_q[1]) begin
            mem_wr_data_o = wdata_q;
        end else if (size_q[0]) begin
            if (addr_q[1]) mem_wr_data_o[31:16] = wdata_q[15:0];
            else           mem_wr_data_o[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    mem_wr_data_o[7:0]   = wdata_q[7:0];
                2'd1:    mem_wr_data_o[15:8]  = wdata_q[7:0];
                2'd2:    mem_wr_data_o[23:16] = wdata_q[7:0];
                default: mem_wr_data_o[31:24] = wdata_q[7:0];
            endcase
        end
    end

    assign mem_rd_addr_o = {addr_q[DEPTH-1:2], 2'b00};
    assign mem_wr_addr_o = {addr_q[DEPTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_write_o <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        addr_q      <= req_addr_i;
                        size_q      <= req_size_i;
                        we_q        <= req_we_i;
                        uns_q       <= req_unsigned_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        if (misaligned) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else if (req_we_i && req_size_i[1]) begin
                            state       <= WR;
                            mem_write_o <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    rdata_q <= mem_rd_data_i;
                    if (we_q) begin
                        state       <= WR;
                        mem_write_o <= 1'b1;
                    end else begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= extract(mem_rd_data_i, addr_q[1:0], size_q, uns_q);
                    end
                end
                WR: begin
                    mem_write_o <= 1'b0;
                    state       <= RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= '0;
                end
                RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases, reset during write, back-to-back and random traffic.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [7:0]  req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [7:0]  mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_write_o;
    logic [7:0]  mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DEPTH(8)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .mem_write_o(mem_write_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o)
    );

    assign mem_rd_data_i = mem[mem_rd_addr_o[7:2]];

    always @(posedge clk) begin
        if (mem_write_o) mem[mem_wr_addr_o[7:2]] <= mem_wr_data_o;
        else if (poke_en) mem[poke_idx] <= poke_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_idx = idx[5:0];
        poke_val = val;
        poke_en  = 1'b1;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Reference: access described as "nbytes at byte offset off within the word".
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] e_rd, output logic e_err, output int e_lat,
                         output int e_wcyc, output logic [31:0] e_wdat);
        int idx, nbytes, off;
        logic bad;
        logic [31:0] w, mask, val;
        idx    = int'(addr) / 4;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        w      = ref_mem[idx];
        bad    = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        bad    = (int'(addr) % nbytes) != 0;
`endif
        off    = ((int'(addr) % 4) / nbytes) * nbytes;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        e_rd = '0; e_err = 1'b0; e_wcyc = 0; e_wdat = '0;
        if (bad) begin
            e_err = 1'b1;
            e_lat = 1;
        end else if (!we) begin
            val = (w >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            e_rd  = val;
            e_lat = 2;
        end else begin
            ref_mem[idx] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            e_lat  = (nbytes == 4) ? 2 : 3;
            e_wcyc = e_lat - 1;
            e_wdat = ref_mem[idx];
        end
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wdata, output logic [31:0] rd);
        logic [31:0] e_rd, e_wdat, wdat;
        logic e_err, err;
        logic [7:0] waddr;
        int e_lat, e_wcyc, lat, writes, wcyc;
        model(we, size, uns, addr, wdata, e_rd, e_err, e_lat, e_wcyc, e_wdat);
        @(negedge clk);
        check("idle_ready", {31'b0, req_ready_o}, 32'd1);
        req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0; writes = 0; wcyc = 0; rd = '0; err = 1'b0; waddr = '0; wdat = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("busy_ready", {31'b0, req_ready_o}, 32'd0);
                check("rd_addr", {24'b0, mem_rd_addr_o}, {24'b0, addr[7:2], 2'b00});
            end
            if (mem_write_o) begin
                writes++; wcyc = k; waddr = mem_wr_addr_o; wdat = mem_wr_data_o;
            end
            if (rsp_valid_o) begin
                lat = k; rd = rsp_rdata_o; err = rsp_err_o;
                break;
            end
        end
        check("latency", lat, e_lat);
        check("rsp_err", {31'b0, err}, {31'b0, e_err});
        check("rsp_rdata", rd, e_rd);
        check("write_count", writes, (e_wcyc != 0) ? 1 : 0);
        if (e_wcyc != 0) begin
            check("write_cycle", wcyc, e_wcyc);
            check("wr_addr", {24'b0, waddr}, {24'b0, addr[7:2], 2'b00});
            check("wr_data", wdat, e_wdat);
        end
        @(negedge clk);
        check("rsp_drop", {31'b0, rsp_valid_o}, 32'd0);
        check("rdata_idle", rsp_rdata_o, 32'd0);
        check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
    endtask

    task automatic back_to_back(input int n);
        logic [31:0] q_rd[$];
        logic q_err[$];
        logic [31:0] e_rd, e_wdat;
        logic e_err;
        int e_lat, e_wcyc, issued, got;
        issued = 0; got = 0;
        for (int cyc = 0; cyc < 50 * n && got < n; cyc++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                if (q_rd.size() == 0) begin
                    check("b2b_extra_rsp", 32'd1, 32'd0);
                end else begin
                    check("b2b_rdata", rsp_rdata_o, q_rd.pop_front());
                    check("b2b_err", {31'b0, rsp_err_o}, {31'b0, q_err.pop_front()});
                end
                got++;
            end
            if (req_ready_o) begin
                if (issued < n) begin
                    req_we_i = 1'($urandom); req_size_i = 2'($urandom);
                    req_unsigned_i = 1'($urandom); req_addr_i = 8'($urandom);
                    req_wdata_i = $urandom;
                    model(req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
                          e_rd, e_err, e_lat, e_wcyc, e_wdat);
                    q_rd.push_back(e_rd);
                    q_err.push_back(e_err);
                    req_valid_i = 1'b1;
                    issued++;
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
        req_valid_i = 1'b0;
        check("b2b_rsp_count", got, n);
        check("b2b_pending", q_rd.size(), 0);
    endtask

    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
        check("rst_rd_addr", {24'b0, mem_rd_addr_o}, 32'd0);
        rst_ni = 1'b1;

        poke(4, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rd); check("lw_10", rd, 32'hDEADBEEF);

        poke(4, 32'h80FF7F01);
        access(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, rd); check("lb_13", rd, 32'hFFFFFF80);
        access(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, rd); check("lbu_13", rd, 32'h00000080);
        access(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, rd); check("lh_12", rd, 32'hFFFF80FF);
        access(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, rd); check("lhu_12", rd, 32'h000080FF);
        access(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, rd); check("lb_10", rd, 32'h00000001);
        access(1'b0, 2'd1, 1'b0, 8'h11, 32'h0, rd);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("lh_11_trap", rd, 32'h0);
`else
        check("lh_11_lane0", rd, 32'h00007F01);
`endif

        poke(4, 32'h11223344);
        access(1'b1, 2'd0, 1'b0, 8'h11, 32'hFFFFFFAA, rd); check("sb_11_mem", mem[4], 32'h1122AA44);
        access(1'b1, 2'd1, 1'b0, 8'h12, 32'h0000BEEF, rd); check("sh_12_mem", mem[4], 32'hBEEFAA44);
        access(1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEF00D, rd);
        access(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, rd); check("lw_20", rd, 32'hCAFEF00D);

        // Reset asserted during the write cycle of a byte store.
        @(negedge clk);
        req_we_i = 1'b1; req_size_i = 2'd0; req_addr_i = 8'h31; req_wdata_i = 32'h000000A5;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1 check("rst_pre_write", {31'b0, mem_write_o}, 32'd1);
        rst_ni = 1'b0;
        #1 check("rst_write_drop", {31'b0, mem_write_o}, 32'd0);
        check("rst_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        check("rst_release_ready", {31'b0, req_ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_quiet", {31'b0, rsp_valid_o}, 32'd0);
        end
        check("rst_mem_kept", mem[12], ref_mem[12]);

        back_to_back(40);
        for (int i = 0; i < 150; i++)
            access(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom, rd);
        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
